// File: rtl/instr_decode_queue.sv
// Instruction decode queue: a small FIFO between fetch and decode.
// The head entry is split combinationally into decode fields, and a NOP is
// presented when the queue is empty. A taken-branch flush empties the queue
// and adds the number of discarded entries to a saturating statistic.
module instr_decode_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PCW   = 64
) (
  input  logic             clk,
  input  logic             rst,
  // fetch side
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [PCW-1:0]   in_pc,
  output logic             in_ready,
  // control
  input  logic             flush,
  // decode side
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      out_instr,
  output logic [PCW-1:0]   out_pc,
  output logic [5:0]       opcode,
  output logic [4:0]       rt,
  output logic [4:0]       ra,
  output logic [4:0]       rb,
  output logic [9:0]       xo,
  output logic             rc,
  output logic [63:0]      si_ext,
  output logic [63:0]      br_off,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]       flush_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NopWord = 32'h6000_0000;
  localparam logic [5:0]  OpBranch = 6'd18;

  // Pointers wrap naturally only when DEPTH is a power of two.
  if ((DEPTH < 2) || (DEPTH > 8) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("instr_decode_queue: DEPTH must be a power of two between 2 and 8");
  end

  // Storage is never reset; it is only visible while count is non-zero.
  logic [31:0]    mem_instr [DEPTH];
  logic [PCW-1:0] mem_pc    [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    flush_cnt_q, flush_cnt_d;

  logic          push;
  logic          pop;
  logic [8:0]    flush_sum;

  // Handshakes depend on registered occupancy only: no out_ready -> in_ready path.
  always_comb begin
    in_ready  = (count_q < CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // Next-state for pointers, occupancy and the saturating flush statistic.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    flush_cnt_d = flush_cnt_q;
    flush_sum   = {1'b0, flush_cnt_q} + 9'(count_q);
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      flush_cnt_d = (flush_sum > 9'd255) ? 8'hFF : flush_sum[7:0];
    end else begin
      if (push) begin
        tail_d = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Entry storage written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail_q] <= in_instr;
      mem_pc[tail_q]    <= in_pc;
    end
  end

  // Head entry, replaced by a NOP at PC 0 when empty.
  always_comb begin
    out_instr = NopWord;
    out_pc    = '0;
    if (count_q != '0) begin
      out_instr = mem_instr[head_q];
      out_pc    = mem_pc[head_q];
    end
  end

  // Decode fields taken straight from the visible head word.
  always_comb begin
    opcode = out_instr[31:26];
    rt     = out_instr[25:21];
    ra     = out_instr[20:16];
    rb     = out_instr[15:11];
    xo     = out_instr[10:1];
    rc     = out_instr[0];
    si_ext = {{48{out_instr[15]}}, out_instr[15:0]};
    // I-form branches carry a 24-bit word offset; everything else uses the 14-bit BD field.
    if (out_instr[31:26] == OpBranch) begin
      br_off = {{38{out_instr[25]}}, out_instr[25:2], 2'b00};
    end else begin
      br_off = {{48{out_instr[15]}}, out_instr[15:2], 2'b00};
    end
  end

  // Registered statistics exported as-is.
  always_comb begin
    count     = count_q;
    flush_cnt = flush_cnt_q;
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue (DEPTH=2, PCW=64) against a
// queue-based reference model.
module tb_instr_decode_queue;

  localparam int DEPTH = 2;
  localparam int PCW   = 64;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h6000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [PCW-1:0]   in_pc = '0;
  logic             in_ready;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [31:0]      out_instr;
  logic [PCW-1:0]   out_pc;
  logic [5:0]       opcode;
  logic [4:0]       rt, ra, rb;
  logic [9:0]       xo;
  logic             rc;
  logic [63:0]      si_ext, br_off;
  logic [CW-1:0]    count;
  logic [7:0]       flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: entries in arrival order plus the flush statistic.
  logic [31:0]    m_instr[$];
  logic [PCW-1:0] m_pc[$];
  int             m_fcnt = 0;

  instr_decode_queue #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc),
    .opcode(opcode), .rt(rt), .ra(ra), .rb(rb), .xo(xo), .rc(rc),
    .si_ext(si_ext), .br_off(br_off), .count(count), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [PCW-1:0] p,
                       input logic fl, input logic ordy);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = p;
    flush     = fl;
    out_ready = ordy;
  endtask

  // Apply the queue rules to the model for the coming edge, then advance to the next negedge.
  task automatic tick();
    int sz = m_instr.size();
    if (flush) begin
      m_fcnt = (m_fcnt + sz > 255) ? 255 : m_fcnt + sz;
      m_instr.delete();
      m_pc.delete();
    end else begin
      bit do_push = in_valid && (sz < DEPTH);
      if (out_ready && sz > 0) begin
        void'(m_instr.pop_front());
        void'(m_pc.pop_front());
      end
      if (do_push) begin
        m_instr.push_back(in_instr);
        m_pc.push_back(in_pc);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_instr !== NOP) begin errors++; $display("FAIL reset_out_instr got %h want %h", out_instr, NOP); end
    checks++; if (out_pc !== '0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    checks++; if (flush_cnt !== 8'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d want 0", flush_cnt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_push();
    drive(1'b1, 32'h3820_0005, 64'h40000, 1'b0, 1'b0);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", out_valid); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", out_valid); end
    checks++; if (opcode !== 6'd14) begin errors++; $display("FAIL single_opcode got %0d want 14", opcode); end
    checks++; if (rt !== 5'd1) begin errors++; $display("FAIL single_rt got %0d want 1", rt); end
    checks++; if (ra !== 5'd0) begin errors++; $display("FAIL single_ra got %0d want 0", ra); end
    checks++; if (si_ext !== 64'd5) begin errors++; $display("FAIL single_si_ext got %h want 5", si_ext); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    checks++; if (out_pc !== 64'h40000) begin errors++; $display("FAIL single_out_pc got %h want 40000", out_pc); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL single_drain got %0d want 0", count); end
  endtask

  task automatic test_full_hold();
    drive(1'b1, 32'h1111_1111, 64'h100, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h2222_2222, 64'h104, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h3333_3333, 64'h108, 1'b0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %b want 0", in_ready); end
    tick(); tick();
    #1;
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL hold_count got %0d want 2", count); end
    checks++; if (out_pc !== 64'h100) begin errors++; $display("FAIL hold_head got %h want 100", out_pc); end
    drive(1'b1, 32'h3333_3333, 64'h108, 1'b0, 1'b1); tick();
    #1;
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL hold_after_pop got %0d want 1", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_again got %b want 1", in_ready); end
    drive(1'b1, 32'h3333_3333, 64'h108, 1'b0, 1'b0); tick();
    #1;
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL hold_accept got %0d want 2", count); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      #1;
      checks++;
      if (out_pc !== 64'h104 + 64'(4 * i)) begin
        errors++; $display("FAIL hold_order got %h want %h", out_pc, 64'h104 + 64'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_stream();
    logic [PCW-1:0] next_pc = 64'h40000;
    logic [PCW-1:0] exp_pc  = 64'h40000;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, next_pc, 1'b0, 1'b0); tick(); next_pc += 4;
    end
    for (int i = 0; i < 20; i++) begin
      bit acc;
      bit pop;
      drive(1'b1, $urandom, next_pc, 1'b0, 1'b1);
      #1;
      acc = (m_instr.size() < DEPTH);
      pop = (m_instr.size() > 0);
      checks++;
      if (count !== CW'(m_instr.size())) begin
        errors++; $display("FAIL stream_count got %0d want %0d", count, m_instr.size());
      end
      if (pop) begin
        checks++;
        if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_pc got %h want %h", out_pc, exp_pc); end
        exp_pc += 4;
      end
      tick();
      if (acc) next_pc += 4;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick(); tick();
  endtask

  task automatic test_flush();
    for (int r = 0; r < 130; r++) begin
      drive(1'b1, $urandom, 64'h500, 1'b0, 1'b0); tick();
      drive(1'b1, $urandom, 64'h504, 1'b0, 1'b0); tick();
      drive(1'b1, $urandom, 64'h508, 1'b1, 1'b1); tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      if (r == 0) begin
        checks++; if (count !== '0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
        checks++; if (out_instr !== NOP) begin errors++; $display("FAIL flush_nop got %h want %h", out_instr, NOP); end
        checks++; if (flush_cnt !== 8'd2) begin errors++; $display("FAIL flush_cnt_first got %0d want 2", flush_cnt); end
      end else begin
        checks++;
        if (flush_cnt !== 8'(m_fcnt)) begin errors++; $display("FAIL flush_cnt got %0d want %0d", flush_cnt, m_fcnt); end
      end
    end
    checks++; if (flush_cnt !== 8'd255) begin errors++; $display("FAIL flush_saturate got %0d want 255", flush_cnt); end
  endtask

  task automatic test_br_off();
    drive(1'b1, 32'h4BFF_FFFC, 64'h600, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h4182_FFF8, 64'h604, 1'b0, 1'b1);
    #1;
    checks++; if (br_off !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL br_off_b got %h want fffffffffffffffc", br_off); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #1;
    checks++; if (br_off !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL br_off_bc got %h want fffffffffffffff8", br_off); end
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h7777_7777, 64'h700, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    m_instr.delete(); m_pc.delete(); m_fcnt = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL arst_count got %0d want 0", count); end
    checks++; if (flush_cnt !== 8'd0) begin errors++; $display("FAIL arst_flush_cnt got %0d want 0", flush_cnt); end
    #1 rst = 1'b1;
    drive(1'b1, 32'h8888_8888, 64'h800, 1'b0, 1'b0); tick();
    #1;
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL arst_push got %0d want 1", count); end
    checks++; if (out_pc !== 64'h800) begin errors++; $display("FAIL arst_pc got %h want 800", out_pc); end
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
    #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL arst_pop got %0d want 0", count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins = $urandom;
      logic [31:0] ei;
      logic [PCW-1:0] ep;
      longint e_si, e_br;
      int sz;
      if ($urandom_range(0, 3) == 0) ins[31:26] = 6'd18;
      drive($urandom_range(0, 9) < 7, ins, {$urandom, $urandom}, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1);
      #1;
      sz = m_instr.size();
      ei = (sz > 0) ? m_instr[0] : NOP;
      ep = (sz > 0) ? m_pc[0] : '0;
      e_si = longint'($signed(ei[15:0]));
      if (ei[31:26] == 6'd18) e_br = longint'($signed(ei[25:2])) * 4;
      else e_br = longint'($signed(ei[15:2])) * 4;
      checks++; if (count !== CW'(sz)) begin errors++; $display("FAIL rnd_count got %0d want %0d", count, sz); end
      checks++; if (out_valid !== (sz > 0)) begin errors++; $display("FAIL rnd_out_valid got %b want %b", out_valid, sz > 0); end
      checks++; if (in_ready !== (sz < DEPTH)) begin errors++; $display("FAIL rnd_in_ready got %b want %b", in_ready, sz < DEPTH); end
      checks++; if (out_instr !== ei) begin errors++; $display("FAIL rnd_out_instr got %h want %h", out_instr, ei); end
      checks++; if (out_pc !== ep) begin errors++; $display("FAIL rnd_out_pc got %h want %h", out_pc, ep); end
      checks++;
      if ({opcode, rt, ra, rb, xo, rc} !== ei) begin
        errors++; $display("FAIL rnd_fields got %h want %h", {opcode, rt, ra, rb, xo, rc}, ei);
      end
      checks++; if (si_ext !== 64'(e_si)) begin errors++; $display("FAIL rnd_si_ext got %h want %h", si_ext, e_si); end
      checks++; if (br_off !== 64'(e_br)) begin errors++; $display("FAIL rnd_br_off got %h want %h", br_off, e_br); end
      checks++; if (flush_cnt !== 8'(m_fcnt)) begin errors++; $display("FAIL rnd_flush_cnt got %0d want %0d", flush_cnt, m_fcnt); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full_hold();
    test_stream();
    test_flush();
    test_br_off();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
